// File: rtl/synth_param_loader_if.sv
// rtl/synth_param_loader_if.sv - 4-wire SPI slave link between host and synth_param_loader
interface synth_param_loader_if;
  logic SCLK;
  logic CS_N;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output CS_N, output MOSI, input MISO);
  modport slave  (input SCLK, input CS_N, input MOSI, output MISO);
endinterface

// File: rtl/synth_param_loader.sv
// rtl/synth_param_loader.sv - SPI-loaded shadow parameter set with atomic apply to the synthesizer
module synth_param_loader #(
  parameter int SYS_FREQ_RATIO = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  synth_param_loader_if.slave  spi,
  output logic                 SIGN_START_GEN,
  output logic [1:0]           SIGNAL_TYPE,
  output logic [31:0]          F_CARRIER,
  output logic [9:0]           T_IMPULSE,
  output logic                 VOBULATION,
  output logic [12:0]          T_PERIOD_1,
  output logic [12:0]          T_PERIOD_2,
  output logic [12:0]          T_PERIOD_3,
  output logic [12:0]          T_PERIOD_4,
  output logic [12:0]          T_PERIOD_5,
  output logic [12:0]          T_PERIOD_6,
  output logic [12:0]          T_PERIOD_7,
  output logic [12:0]          T_PERIOD_8,
  output logic [12:0]          T_PERIOD_9,
  output logic [12:0]          T_PERIOD_10,
  output logic [4:0]           NUM_OF_IMP,
  output logic [21:0]          DEVIATION,
  output logic                 ERR
);

  if (SYS_FREQ_RATIO < 4) begin : g_ratio_check
    $error("synth_param_loader: SYS_FREQ_RATIO must be at least 4");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]  r_sclk_s, r_cs_s, r_mosi_s;
  logic        r_sclk_d, r_cs_d;
  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [39:0] r_shift;
  logic [31:0] r_rd_data;
  logic        r_miso;

  logic [31:0] r_sh_fc, r_act_fc;
  logic [9:0]  r_sh_timp, r_act_timp;
  logic [1:0]  r_sh_type, r_act_type;
  logic        r_sh_vob, r_act_vob;
  logic [4:0]  r_sh_num, r_act_num;
  logic [21:0] r_sh_dev, r_act_dev;
  logic [12:0] r_sh_period [10];
  logic [12:0] r_act_period [10];
  logic        r_ssg, r_err;

  logic        w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic [5:0]  w_cnt_next;
  logic [39:0] w_shift_next;
  logic [6:0]  w_rd_addr;
  logic [31:0] w_rd_val;
  logic        w_wr;
  logic [6:0]  w_addr;
  logic [31:0] w_data;
  logic        w_valid;

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_cs_fall   = ~r_cs_s[1] & r_cs_d;
  assign w_cs_rise   = r_cs_s[1] & ~r_cs_d;

  // The SCLK edge of this cycle is folded in before the frame-end check.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    if (w_sclk_rise) begin
      w_shift_next = {r_shift[38:0], r_mosi_s[1]};
      if (r_cnt != 6'd41) w_cnt_next = r_cnt + 6'd1;
    end
  end

  assign w_rd_addr = {r_shift[5:0], r_mosi_s[1]};

  always_comb begin
    w_rd_val = '0;
    case (w_rd_addr)
      7'h00:   w_rd_val = r_sh_fc;
      7'h01:   w_rd_val = {22'd0, r_sh_timp};
      7'h02:   w_rd_val = {23'd0, r_sh_vob, 6'd0, r_sh_type};
      7'h03:   w_rd_val = {27'd0, r_sh_num};
      7'h04:   w_rd_val = {10'd0, r_sh_dev};
      7'h10:   w_rd_val = {30'd0, r_err, r_ssg};
      default: w_rd_val = '0;
    endcase
    for (int k = 0; k < 10; k++) begin
      if (w_rd_addr == 7'(k + 5)) w_rd_val = {19'd0, r_sh_period[k]};
    end
  end

  assign w_wr    = r_shift[39];
  assign w_addr  = r_shift[38:32];
  assign w_data  = r_shift[31:0];
  assign w_valid = (r_sh_timp != '0) && (r_sh_type != '0) && (r_sh_num != '0);

  // Sync flops reset low so a CS_N already low at release is not taken as a frame start.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sclk_s   <= '0;
      r_cs_s     <= '0;
      r_mosi_s   <= '0;
      r_sclk_d   <= 1'b0;
      r_cs_d     <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rd_data  <= '0;
      r_miso     <= 1'b0;
      r_sh_fc    <= '0;
      r_sh_timp  <= '0;
      r_sh_type  <= '0;
      r_sh_vob   <= 1'b0;
      r_sh_num   <= '0;
      r_sh_dev   <= '0;
      r_act_fc   <= '0;
      r_act_timp <= '0;
      r_act_type <= '0;
      r_act_vob  <= 1'b0;
      r_act_num  <= '0;
      r_act_dev  <= '0;
      for (int k = 0; k < 10; k++) begin
        r_sh_period[k]  <= '0;
        r_act_period[k] <= '0;
      end
      r_ssg      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], spi.SCLK};
      r_cs_s   <= {r_cs_s[0], spi.CS_N};
      r_mosi_s <= {r_mosi_s[0], spi.MOSI};
      r_sclk_d <= r_sclk_s[1];
      r_cs_d   <= r_cs_s[1];

      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_cnt   <= w_cnt_next;
          r_shift <= w_shift_next;
          if (w_sclk_rise && r_cnt == 6'd7) r_rd_data <= w_rd_val;
          if (w_sclk_fall) begin
            if (r_cnt >= 6'd8 && r_cnt < 6'd40) begin
              r_miso    <= r_rd_data[31];
              r_rd_data <= {r_rd_data[30:0], 1'b0};
            end else begin
              r_miso <= 1'b0;
            end
          end
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_state <= (w_cnt_next == 6'd40) ? S_COMMIT : S_IDLE;
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          if (w_wr) begin
            case (w_addr)
              7'h00: r_sh_fc   <= w_data;
              7'h01: r_sh_timp <= w_data[9:0];
              7'h02: begin
                r_sh_type <= w_data[1:0];
                r_sh_vob  <= w_data[8];
              end
              7'h03: r_sh_num  <= w_data[4:0];
              7'h04: r_sh_dev  <= w_data[21:0];
              7'h0F: begin
                if (w_data[2]) r_err <= 1'b0;
                if (w_data[1]) begin
                  r_ssg <= 1'b0;
                end else if (w_data[0]) begin
                  if (w_valid) begin
                    r_act_fc   <= r_sh_fc;
                    r_act_timp <= r_sh_timp;
                    r_act_type <= r_sh_type;
                    r_act_vob  <= r_sh_vob;
                    r_act_num  <= r_sh_num;
                    r_act_dev  <= r_sh_dev;
                    r_act_period <= r_sh_period;
                    r_ssg      <= 1'b1;
                  end else begin
                    r_err <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
            for (int k = 0; k < 10; k++) begin
              if (w_addr == 7'(k + 5)) r_sh_period[k] <= w_data[12:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi.MISO       = r_miso & ~spi.CS_N;
  assign SIGN_START_GEN = r_ssg;
  assign ERR            = r_err;
  assign SIGNAL_TYPE    = r_act_type;
  assign F_CARRIER      = r_act_fc;
  assign T_IMPULSE      = r_act_timp;
  assign VOBULATION     = r_act_vob;
  assign NUM_OF_IMP     = r_act_num;
  assign DEVIATION      = r_act_dev;
  assign T_PERIOD_1     = r_act_period[0];
  assign T_PERIOD_2     = r_act_period[1];
  assign T_PERIOD_3     = r_act_period[2];
  assign T_PERIOD_4     = r_act_period[3];
  assign T_PERIOD_5     = r_act_period[4];
  assign T_PERIOD_6     = r_act_period[5];
  assign T_PERIOD_7     = r_act_period[6];
  assign T_PERIOD_8     = r_act_period[7];
  assign T_PERIOD_9     = r_act_period[8];
  assign T_PERIOD_10    = r_act_period[9];

endmodule
